// File: rtl/maxpool2x2_engine_if.sv
// Control and buffer-port bundle for maxpool2x2_engine.
//   master : the wrapper side, which drives start and returns input-buffer read data.
//   slave  : the engine, which drives busy/done, the input-buffer read address and the
//            output-buffer write port.
// Signals:
//   start          one-cycle start request
//   done           one-cycle completion pulse
//   busy           run in progress (first cycle after start through the done cycle)
//   bufferIn_adr   input-buffer read address, row-major
//   bufferIn_data  input-buffer read data (combinational read of bufferIn_adr)
//   bufferOut_adr  output-buffer write address, row-major
//   bufferOut_data output-buffer write data
//   bufferOut_wr   output-buffer write strobe
interface maxpool2x2_engine_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IMG_H      = 4,
  parameter int unsigned IMG_W      = 4
);
  localparam int unsigned IN_NUM        = IMG_H * IMG_W;
  localparam int unsigned OUT_NUM       = (IMG_H / 2) * (IMG_W / 2);
  localparam int unsigned IN_ADR_WIDTH  = $clog2(IN_NUM);
  // A 2x2 image has a single output word; keep the address at least one bit wide.
  localparam int unsigned OUT_ADR_WIDTH = (OUT_NUM > 1) ? $clog2(OUT_NUM) : 1;

  logic                     start;
  logic                     done;
  logic                     busy;
  logic [IN_ADR_WIDTH-1:0]  bufferIn_adr;
  logic [DATA_WIDTH-1:0]    bufferIn_data;
  logic [OUT_ADR_WIDTH-1:0] bufferOut_adr;
  logic [DATA_WIDTH-1:0]    bufferOut_data;
  logic                     bufferOut_wr;

  modport master (
    output start,
    output bufferIn_data,
    input  done,
    input  busy,
    input  bufferIn_adr,
    input  bufferOut_adr,
    input  bufferOut_data,
    input  bufferOut_wr
  );

  modport slave (
    input  start,
    input  bufferIn_data,
    output done,
    output busy,
    output bufferIn_adr,
    output bufferOut_adr,
    output bufferOut_data,
    output bufferOut_wr
  );
endinterface

// File: rtl/maxpool2x2_engine.sv
// 2x2 stride-2 signed max pooling engine (pooling stage of the MNIST CNN datapath).
// On an accepted start it reads an IMG_H x IMG_W map from the input buffer, four taps per
// window, keeps the signed maximum, writes one word per window to the output buffer and
// pulses done. Every window costs 5 cycles (4 reads + 1 write); done follows the last write.
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset (aborts any run, no done)
//   bus_io maxpool2x2_engine_if.slave: start/done/busy and both buffer ports
// Build option:
//   MAXPOOL_RELU_EN  when defined, negative pooled results are written as 0 (fused ReLU).
module maxpool2x2_engine #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IMG_H      = 4,
  parameter int unsigned IMG_W      = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  maxpool2x2_engine_if.slave     bus_io
);
  localparam int unsigned IN_NUM        = IMG_H * IMG_W;
  localparam int unsigned OUT_NUM       = (IMG_H / 2) * (IMG_W / 2);
  localparam int unsigned IN_ADR_WIDTH  = $clog2(IN_NUM);
  localparam int unsigned OUT_ADR_WIDTH = (OUT_NUM > 1) ? $clog2(OUT_NUM) : 1;
  localparam int unsigned WIN_ROWS      = IMG_H / 2;
  localparam int unsigned WIN_COLS      = IMG_W / 2;
  localparam int unsigned WR_WIDTH      = (WIN_ROWS > 1) ? $clog2(WIN_ROWS) : 1;
  localparam int unsigned WC_WIDTH      = (WIN_COLS > 1) ? $clog2(WIN_COLS) : 1;

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StFin} state_e;

  state_e                  state_q, state_d;
  logic [WR_WIDTH-1:0]     wr_q, wr_d;
  logic [WC_WIDTH-1:0]     wc_q, wc_d;
  logic [1:0]              k_q, k_d;
  logic [DATA_WIDTH-1:0]   acc_q, acc_d;
  // Low for the first edge after reset release so a start seen at that edge is ignored.
  logic                    armed_q;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    last_col, last_row;

  assign last_col = (wc_q == WC_WIDTH'(WIN_COLS - 1));
  assign last_row = (wr_q == WR_WIDTH'(WIN_ROWS - 1));

`ifdef MAXPOOL_RELU_EN
  assign wr_data = acc_q[DATA_WIDTH-1] ? '0 : acc_q;
`else
  assign wr_data = acc_q;
`endif

  always_comb begin
    state_d               = state_q;
    wr_d                  = wr_q;
    wc_d                  = wc_q;
    k_d                   = k_q;
    acc_d                 = acc_q;
    bus_io.done           = 1'b0;
    bus_io.busy           = (state_q != StIdle);
    bus_io.bufferIn_adr   = '0;
    bus_io.bufferOut_adr  = '0;
    bus_io.bufferOut_data = '0;
    bus_io.bufferOut_wr   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus_io.start && armed_q) begin
          state_d = StRead;
          wr_d    = '0;
          wc_d    = '0;
          k_d     = '0;
        end
      end
      StRead: begin
        // k[1] selects the lower row of the window, k[0] the right column.
        bus_io.bufferIn_adr = IN_ADR_WIDTH'((2 * 32'(wr_q) + 32'(k_q[1])) * IMG_W
                                            + 2 * 32'(wc_q) + 32'(k_q[0]));
        // Strict greater-than: on a tie the accumulator keeps its value.
        if ((k_q == 2'd0) || ($signed(bus_io.bufferIn_data) > $signed(acc_q))) begin
          acc_d = bus_io.bufferIn_data;
        end
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        bus_io.bufferOut_wr   = 1'b1;
        bus_io.bufferOut_adr  = OUT_ADR_WIDTH'(32'(wr_q) * WIN_COLS + 32'(wc_q));
        bus_io.bufferOut_data = wr_data;
        state_d               = StRead;
        if (last_col) begin
          wc_d = '0;
          if (last_row) begin
            state_d = StFin;
          end else begin
            wr_d = wr_q + 1'b1;
          end
        end else begin
          wc_d = wc_q + 1'b1;
        end
      end
      StFin: begin
        bus_io.done = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      wr_q    <= '0;
      wc_q    <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      wc_q    <= wc_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      armed_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_maxpool2x2_engine.sv
// Scoreboard bench for maxpool2x2_engine: a 4x4 instance for directed cases and a 28x28
// instance for the MNIST-sized run. Expected writes/done cycles are queued by the stimulus
// and popped by per-instance monitors sampling on the falling edge.
module tb_maxpool2x2_engine;
  localparam int unsigned DW = 32;

  typedef struct {
    int unsigned adr;
    logic [DW-1:0] data;
    int unsigned cyc;
  } wr_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  maxpool2x2_engine_if #(.DATA_WIDTH(DW), .IMG_H(4), .IMG_W(4)) bus4 ();
  maxpool2x2_engine_if #(.DATA_WIDTH(DW), .IMG_H(28), .IMG_W(28)) bus28 ();

  maxpool2x2_engine #(.DATA_WIDTH(DW), .IMG_H(4), .IMG_W(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_io(bus4)
  );

  maxpool2x2_engine #(.DATA_WIDTH(DW), .IMG_H(28), .IMG_W(28)) u_dut28 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_io(bus28)
  );

  logic [DW-1:0] mem4 [16];
  logic [DW-1:0] mem28 [784];
  assign bus4.bufferIn_data  = mem4[bus4.bufferIn_adr];
  assign bus28.bufferIn_data = mem28[bus28.bufferIn_adr];

  wr_exp_t     wq4[$];
  wr_exp_t     wq28[$];
  int unsigned dq4[$];
  int unsigned dq28[$];
  int unsigned t0_4 = 0;
  int unsigned t0_28 = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pool_out(input logic [DW-1:0] v);
`ifdef MAXPOOL_RELU_EN
    return v[DW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  task automatic push4(input int unsigned adr, input logic [DW-1:0] data, input int unsigned c);
    wr_exp_t e;
    e.adr = adr; e.data = data; e.cyc = c;
    wq4.push_back(e);
  endtask

  task automatic set_win4(input int unsigned w, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] c, input logic [DW-1:0] d);
    int unsigned base;
    base = (w / 2) * 8 + (w % 2) * 2;
    mem4[base] = a; mem4[base + 1] = b; mem4[base + 4] = c; mem4[base + 5] = d;
  endtask

  // Monitor for the 4x4 instance.
  always @(negedge clk) begin
    int unsigned rel;
    wr_exp_t e;
    rel = cyc - t0_4;
    if (bus4.bufferOut_wr === 1'b1) begin
      chk("wr4_expected", longint'(wq4.size() != 0), 1);
      if (wq4.size() != 0) begin
        e = wq4.pop_front();
        chk("wr4_adr", bus4.bufferOut_adr, e.adr);
        chk("wr4_data", bus4.bufferOut_data, e.data);
        chk("wr4_cycle", rel, e.cyc);
      end
    end else begin
      chk("idle4_out_zero", {bus4.bufferOut_adr, bus4.bufferOut_data}, 0);
    end
    if (bus4.busy !== 1'b1) chk("idle4_in_adr_zero", bus4.bufferIn_adr, 0);
    if (bus4.done === 1'b1) begin
      chk("done4_expected", longint'(dq4.size() != 0), 1);
      if (dq4.size() != 0) chk("done4_cycle", rel, dq4.pop_front());
    end
  end

  // Monitor for the 28x28 instance.
  always @(negedge clk) begin
    int unsigned rel;
    wr_exp_t e;
    rel = cyc - t0_28;
    if (bus28.bufferOut_wr === 1'b1) begin
      chk("wr28_expected", longint'(wq28.size() != 0), 1);
      if (wq28.size() != 0) begin
        e = wq28.pop_front();
        chk("wr28_adr", bus28.bufferOut_adr, e.adr);
        chk("wr28_data", bus28.bufferOut_data, e.data);
        chk("wr28_cycle", rel, e.cyc);
      end
    end
    if (bus28.done === 1'b1) begin
      chk("done28_expected", longint'(dq28.size() != 0), 1);
      if (dq28.size() != 0) chk("done28_cycle", rel, dq28.pop_front());
    end
  end

  // One 4x4 run: start at edge 0, optional extra start pulse during cycle extra_rel.
  task automatic run4(input int unsigned extra_rel);
    int unsigned busy_bad;
    busy_bad = 0;
    @(negedge clk);
    bus4.start = 1'b1;
    t0_4 = cyc;
    for (int unsigned rel = 1; rel <= 27; rel++) begin
      @(negedge clk);
      bus4.start = (rel == extra_rel);
      if (bus4.busy !== (rel <= 21)) busy_bad++;
    end
    bus4.start = 1'b0;
    chk("busy4_window", busy_bad, 0);
    chk("wr4_drained", wq4.size(), 0);
    chk("done4_drained", dq4.size(), 0);
  endtask

  task automatic push_ramp4();
    push4(0, 5, 5); push4(1, 7, 10); push4(2, 13, 15); push4(3, 15, 20);
    dq4.push_back(21);
  endtask

  initial begin
    int unsigned busy_bad;
    bus4.start  = 1'b0;
    bus28.start = 1'b0;
    for (int i = 0; i < 16; i++) mem4[i] = DW'(i);
    for (int i = 0; i < 784; i++) mem28[i] = DW'(i);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", bus4.busy, 0);
    chk("rst_done", bus4.done, 0);
    chk("rst_wr", bus4.bufferOut_wr, 0);
    chk("rst_in_adr", bus4.bufferIn_adr, 0);
    chk("rst_out", {bus4.bufferOut_adr, bus4.bufferOut_data}, 0);

    // Start coinciding with reset release is ignored
    bus4.start = 1'b1;
    #2 rst_n = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    busy_bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus4.busy !== 1'b0) busy_bad++;
    end
    chk("start_at_rst_release_ignored", busy_bad, 0);

    // Ramp 0..15
    push_ramp4();
    run4(0);

    // Signed window in every position
    for (int w = 0; w < 4; w++) begin
      set_win4(w, -32'sd7, -32'sd3, -32'sd9, -32'sd100);
      push4(w, pool_out(32'hFFFF_FFFD), 5 * (w + 1));
    end
    dq4.push_back(21);
    run4(0);

    // Ties and extremes
    set_win4(0, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0);
    set_win4(1, 32'h5, 32'h5, 32'h5, 32'h5);
    set_win4(2, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    set_win4(3, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
    push4(0, 32'h7FFF_FFFF, 5);
    push4(1, 32'h5, 10);
    push4(2, pool_out(32'h8000_0000), 15);
    push4(3, pool_out(32'hFFFF_FFFF), 20);
    dq4.push_back(21);
    run4(0);

    // Second start mid-run is ignored, then a fresh run after done
    for (int i = 0; i < 16; i++) mem4[i] = DW'(i);
    push_ramp4();
    run4(8);
    for (int i = 0; i < 16; i++) mem4[i] = DW'(15 - i);
    push4(0, 15, 5); push4(1, 13, 10); push4(2, 7, 15); push4(3, 5, 20);
    dq4.push_back(21);
    run4(0);

    // Reset at cycle 7 aborts the run
    for (int i = 0; i < 16; i++) mem4[i] = DW'(i);
    push4(0, 5, 5);
    @(negedge clk);
    bus4.start = 1'b1;
    t0_4 = cyc;
    @(negedge clk);
    bus4.start = 1'b0;
    while (cyc - t0_4 < 7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", bus4.busy, 0);
    chk("abort_wr", bus4.bufferOut_wr, 0);
    chk("abort_in_adr", bus4.bufferIn_adr, 0);
    chk("abort_done", bus4.done, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (25) @(negedge clk);
    chk("abort_writes_seen", wq4.size(), 0);

    // Clean run after the aborted one
    for (int i = 0; i < 16; i++) mem4[i] = DW'(3 * i) - 32'd20;
    push4(0, pool_out(32'hFFFF_FFFB), 5);
    push4(1, 32'd1, 10);
    push4(2, 32'd19, 15);
    push4(3, 32'd25, 20);
    dq4.push_back(21);
    run4(0);

    // MNIST-sized 28x28, input value = address
    for (int unsigned k = 0; k < 196; k++) begin
      wr_exp_t e;
      e.adr  = k;
      e.data = DW'((2 * (k / 14) + 1) * 28 + 2 * (k % 14) + 1);
      e.cyc  = 5 * (k + 1);
      wq28.push_back(e);
    end
    dq28.push_back(981);
    @(negedge clk);
    bus28.start = 1'b1;
    t0_28 = cyc;
    @(negedge clk);
    bus28.start = 1'b0;
    repeat (995) @(negedge clk);
    chk("wr28_drained", wq28.size(), 0);
    chk("done28_drained", dq28.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/maxpool2x2_engine.md
Name: maxpool2x2_engine

Overview:
- Compute core on the wrapper side of the AXI-Stream interface block.
- Started by that block's start pulse. Reads one IMG_H x IMG_W feature map from its input buffer, performs 2x2 stride-2 signed max pooling, and writes the (IMG_H/2) x (IMG_W/2) result into its output buffer.
- Signals completion with a one-cycle done pulse. This is the pooling stage of the MNIST CNN datapath.

Parameters:
- DATA_WIDTH, 32, word width; buffer words are two's-complement signed.
- IMG_H, 4, input rows; even, >=2.
- IMG_W, 4, input columns; even, >=2.
- Derived: IN_NUM=IMG_H*IMG_W; OUT_NUM=(IMG_H/2)*(IMG_W/2); IN_ADR_WIDTH=$clog2(IN_NUM); OUT_ADR_WIDTH=$clog2(OUT_NUM).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- start  in  1  one-cycle start request; ignored unless idle.
- done  out  1  one-cycle completion pulse.
- busy  out  1  high from first cycle after accepted start through done cycle.
- bufferIn_adr  out  IN_ADR_WIDTH  input-buffer read address, row-major (r*IMG_W+c).
- bufferIn_data  in  DATA_WIDTH  input-buffer read data; combinational read of bufferIn_adr, sampled at the same clock edge.
- bufferOut_adr  out  OUT_ADR_WIDTH  output-buffer write address, row-major.
- bufferOut_data  out  DATA_WIDTH  output-buffer write data.
- bufferOut_wr  out  1  output-buffer write strobe, one cycle per result.

Behaviour:
- Reset: rst_n asynchronous, active-low; clock clk, rising edge.
  - On reset: state IDLE; counters, accumulator and all outputs = 0.
  - Reset mid-run aborts the run with no further writes and no done pulse.
- FSM states: IDLE, READ, WRITE, FIN.
  - IDLE: start=1 → READ. Clears window row wr=0, window col wc=0, tap k=0 on entry.
  - READ: 4 cycles, k=0..3.
    - Taps: k=0 (2wr,2wc), k=1 (2wr,2wc+1), k=2 (2wr+1,2wc), k=3 (2wr+1,2wc+1).
    - bufferIn_adr = tap address.
    - k=0: acc<=bufferIn_data. k>0: acc<=signed max(acc, bufferIn_data); ties keep acc.
    - After k=3 → WRITE.
  - WRITE: 1 cycle.
    - bufferOut_wr=1, bufferOut_adr=wr*(IMG_W/2)+wc, bufferOut_data=acc.
    - Then advance wc; on wrap, wc=0 and wr+1.
    - Last window (wr=IMG_H/2-1, wc=IMG_W/2-1) → FIN; else → READ with k=0.
  - FIN: done=1 for one cycle → IDLE.
- Outputs when not in WRITE: bufferOut_wr=0, bufferOut_adr=0, bufferOut_data=0. bufferIn_adr=0 outside READ.
- Latency: start sampled at edge 0. Reads occupy cycles 1..4, first write in cycle 5. Window n write in cycle 5(n+1). done in cycle 5*OUT_NUM+1 (21 for 4x4). busy high cycles 1..5*OUT_NUM+1.
- Signed comparison on full DATA_WIDTH. No width growth; output width = input width.
- start while busy or in FIN: ignored, no queueing. start in the same cycle as reset deassertion: ignored.
- Input buffer must stay stable between start and done; the interface block enforces this by not touching buffers while waiting for done.

Optional Feature:
- Macro: MAXPOOL_RELU_EN.
- Defined: WRITE outputs max(acc, 0), i.e. negative pooled results are written as 0. Fused ReLU.
- Undefined: acc is written unmodified.
- Timing and latency are identical in both builds.

Test Plan:
- 4x4 ramp input 0..15, start pulse → writes adr0=5, adr1=7, adr2=13, adr3=15 in cycles 5,10,15,20; done=1 only in cycle 21; busy cycles 1..21.
- Signed window (-7, -3, -9, -100) in all windows, build without MAXPOOL_RELU_EN → all outputs 0xFFFFFFFD (-3). Rebuild with MAXPOOL_RELU_EN → all outputs 0.
- Ties and extremes: window (0x7FFFFFFF, 0x80000000, 0x7FFFFFFF, 0) → 0x7FFFFFFF. All-equal window 0x5 → 0x5.
- Second start pulse at cycle 8 during a run → no restart; exactly 4 writes; single done at cycle 21. New start after done → full second run with correct results.
- rst_n low at cycle 7 → outputs 0 immediately (async), no writes after, no done. Start after release → clean full run.
- IMG_H=28, IMG_W=28 (MNIST), input value = adr → output k=(i,j) equals (2i+1)*28+2j+1; 196 writes; done at cycle 981.
